// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 datapath stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_RD = 4'd1,
        ST_LEN_WR = 4'd2,
        ST_RD_I   = 4'd3,
        ST_RD_J   = 4'd4,
        ST_WR_I   = 4'd5,
        ST_WR_J   = 4'd6,
        ST_RD_PAD = 4'd7,
        ST_WR_PT  = 4'd8
    } prga_state_t;

    // Length byte lives at address 0 of both message RAMs.
    localparam byte_t LEN_ADDR = 8'd0;

endpackage

// File: rtl/prga.sv
// ARC4 keystream generation + decryption: reads S/ct RAMs, writes plaintext RAM.
// Latency: busy for 2 + 6*L cycles after an accepted start (L = ct[0]).
// Backpressure: en is accepted only while rdy=1; en while busy is ignored.
module prga
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    prga_state_t state;
    byte_t       k;      // message byte index; also serves as the RC4 i counter
    byte_t       j;
    byte_t       si;
    byte_t       sj;
    byte_t       ctk;
    byte_t       len;

    // S[k] arrives during RD_J, so the new j has to be formed from live read data
    // to address S[j] in the same cycle.
    byte_t j_new;
    byte_t pad_idx;
    assign j_new   = j + s_rddata;
    assign pad_idx = si + sj;

    // FSM and datapath registers; one keystream byte every six cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            ctk   <= 8'd0;
            len   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LEN_RD;
                end
                ST_LEN_RD: state <= ST_LEN_WR;
                ST_LEN_WR: begin
                    len   <= ct_rddata;
                    j     <= 8'd0;
                    k     <= 8'd1;
                    state <= (ct_rddata == 8'd0) ? ST_IDLE : ST_RD_I;
                end
                ST_RD_I: state <= ST_RD_J;
                ST_RD_J: begin
                    si    <= s_rddata;
                    ctk   <= ct_rddata;
                    j     <= j_new;
                    state <= ST_WR_I;
                end
                ST_WR_I: begin
                    sj    <= s_rddata;
                    state <= ST_WR_J;
                end
                ST_WR_J:   state <= ST_RD_PAD;
                ST_RD_PAD: state <= ST_WR_PT;
                ST_WR_PT: begin
                    if (k == len) begin
                        state <= ST_IDLE;
                    end else begin
                        k     <= k + 8'd1;
                        state <= ST_RD_I;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM controls decoded from state; idle fields park at zero.
    always_comb begin
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state)
            ST_IDLE: rdy = 1'b1;
            ST_LEN_RD: ct_addr = LEN_ADDR;
            ST_LEN_WR: begin
                pt_addr   = LEN_ADDR;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
            end
            ST_RD_I: begin
                s_addr  = k;
                ct_addr = k;
            end
            ST_RD_J: s_addr = j_new;
            ST_WR_I: begin
                // S[j] is on the read bus this cycle; write it straight into S[k].
                s_addr   = k;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
            end
            ST_WR_J: begin
                // When j==k this overwrites the WR_I result with si, as RC4 requires.
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
            end
            ST_RD_PAD: s_addr = pad_idx;
            ST_WR_PT: begin
                pt_addr   = k;
                pt_wrdata = s_rddata ^ ctk;
                pt_wren   = 1'b1;
            end
            default: rdy = 1'b0;
        endcase
    end

endmodule

// File: doc/prga.md
# prga

Pseudo-random generation and decryption stage of the ARC4 datapath. Once the key-scheduling stage has finished writing the permuted state array S, this block is the reader of S. It reads a length-prefixed ciphertext message, continues the S swap sequence to generate one keystream byte per message byte, and writes the length-prefixed plaintext. It uses the same en/rdy start handshake as the other ARC4 stages and drives three single-port synchronous RAMs (S, CT, PT).

## Interface
Parameters:
- none; all widths are fixed at 8-bit data and 8-bit addresses.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- s_addr  out  8  S RAM address.
- s_rddata  in  8  S RAM read data.
- s_wrdata  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- ct_addr  out  8  ciphertext RAM address; read-only.
- ct_rddata  in  8  ciphertext RAM read data.
- pt_addr  out  8  plaintext RAM address.
- pt_wrdata  out  8  plaintext RAM write data.
- pt_wren  out  1  plaintext RAM write enable.

## Operation
- Memory model for all three RAMs:
  - An address driven in cycle t returns its rddata during cycle t+1; the FSM samples it at the end of t+1.
  - A write takes effect at the edge ending the cycle in which wren=1.
- Message format:
  - ct[0] = L, the message length (0..255); ct[1..L] hold the ciphertext bytes.
  - The block writes pt[0] = L and pt[1..L] = plaintext.
- Internal registers: k (byte index, 8b), j (8b), si, sj, ctk, L. i equals k throughout (k ≤ 255), so there is no separate i counter.
- FSM states:
  - IDLE: rdy=1, all wren=0. On en=1, go to LEN_RD.
  - LEN_RD: ct_addr=0.
  - LEN_WR: latch L=ct_rddata; drive pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1; set j=0, k=1. If ct_rddata=0, go to IDLE; otherwise go to RD_I.
  - RD_I: s_addr=k, ct_addr=k.
  - RD_J: latch si=s_rddata and ctk=ct_rddata; compute j=(j+si) mod 256; drive s_addr to the new j.
  - WR_I: latch sj=s_rddata; s_addr=k, s_wrdata=sj, s_wren=1.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1.
  - RD_PAD: s_addr=(si+sj) mod 256.
  - WR_PT: pt_addr=k, pt_wrdata=s_rddata ^ ctk, pt_wren=1. If k==L, go to IDLE; otherwise k=k+1 and go to RD_I.
- Arithmetic: all additions are 8-bit and wrap mod 256, with the carry discarded.
- Aliasing: when j==k, WR_I and WR_J write the same location; the final value is si, which is correct RC4 behaviour.
- en while rdy=0 is ignored. en held high continuously starts a new run on the first IDLE cycle.
- Unused outputs in each state:
  - Addresses hold 0, and wrdata holds 0.
  - Any wren not listed for a state is 0.

## Timing
- Reset values:
  - State is IDLE, rdy=1.
  - All addr and wrdata outputs are 0; s_wren=pt_wren=0.
  - j=k=L=si=sj=ctk=0.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronously); any partially swapped S is not repaired.
- Start: en=1 with rdy=1 at edge E0 makes rdy=0 in the cycle after E0.
- Busy duration:
  - Busy lasts exactly 2 + 6·L cycles.
  - rdy=1 again in the cycle after the final WR_PT, or after LEN_WR when L=0.
- Outputs are Moore: a function of the current state and registers only, with no combinational path from en.
  - Exceptions: pt_wrdata in LEN_WR and WR_PT is derived from same-cycle rddata.

## Structure
- Shared package arc4_pkg holds:
  - the prga_state_t enum;
  - the byte typedef (8-bit);
  - the constant LEN_ADDR=8'd0.
- No sub-module; the block is a single FSM plus datapath, expected to be about 150–250 lines of RTL.

## Test plan
- Identity S (S[x]=x), ct = {0x01, 0x00}:
  - Expected: pt[0]=0x01, pt[1]=0x02; S unchanged.
  - rdy is low for 8 cycles.
- Identity S, ct = {0x02, 0x00, 0x00}:
  - Expected: pt = {0x02, 0x02, 0x05}; S[2]=0x03, S[3]=0x02; final j=0x03.
  - rdy is low for 14 cycles.
- ct[0]=0x00: pt[0]=0x00, no S writes, rdy is low for exactly 2 cycles.
- Identity S, ct = {0xFF, 0xFF, …}: exercises j wrap-around and k reaching 255.
  - Compare every pt byte against a reference model.
  - rdy returns after 1532 cycles.
- Pulse en while busy: no effect. Hold en high: a second run starts the cycle rdy is observed high.
- Assert rst_n low in WR_I:
  - Expected: rdy=1, s_wren=0, pt_wren=0 immediately.
  - A new en then runs cleanly from LEN_RD.
